lsu16: RTL and testbench
========================

Name: lsu16

Overview:
- Load/store unit sitting directly downstream of the 16-register file.
- Consumes the store address (Rs contents) and store data (Rt contents) and runs a req/ack transaction to data memory.
- Returns load data to the register file write port as a single-cycle write (regwr, destination address, write data).
- Stalls the issuing pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 255: max cycles waiting for mem_ack before abort. Range 1..65535.
- TO_W, 16: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ls_valid  in  1  request valid from decode.
- ls_write  in  1  1=store, 0=load.
- ls_addr  in  16  word address (regfile Rs output).
- ls_wdata  in  16  store data (regfile Rt output).
- ls_rd  in  4  load destination register.
- ls_ready  out  1  unit can accept a request this cycle.
- stall  out  1  pipeline stall (= ls_valid & ~ls_ready).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  16  read data, valid with mem_ack.
- wb_regwr  out  1  register file write enable.
- wb_add_Rd  out  4  register file write address.
- wb_data  out  16  register file write data.
- err  out  1  timeout pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wb_regwr=0, wb_add_Rd=0, wb_data=0.
  - err=0, timeout counter=0.
  - ls_ready=1 (combinational from IDLE).
- Reset mid-transaction drops mem_req immediately. No writeback is issued and no err pulse is generated.
- FSM states: IDLE, REQ, WB.
- IDLE:
  - ls_ready=1.
  - Accept on ls_valid=1 at a rising edge. Register ls_write, ls_addr, ls_wdata, ls_rd.
  - Go to REQ, with mem_req=1 from the next cycle.
  - mem_we=ls_write. mem_wdata is driven for stores and held at its previous value for loads.
- REQ:
  - ls_ready=0. mem_req, mem_we, mem_addr, mem_wdata held stable until ack.
  - Counter increments each cycle without ack.
  - mem_ack=1, store: mem_req=0 next cycle, go to IDLE.
  - mem_ack=1, load: capture mem_rdata into wb_data, go to WB, mem_req=0.
  - Counter reaches TIMEOUT without ack: mem_req=0, err=1 for one cycle, go to IDLE, no writeback.
  - Ack and timeout in the same cycle: ack wins, no err.
- WB:
  - wb_regwr=1 for exactly one cycle, wb_add_Rd=captured rd, wb_data=captured load data.
  - Go to IDLE. ls_ready=0 during WB.
- Register 0: a load with rd=0 performs the memory read but suppresses wb_regwr. The unit still passes through WB for uniform timing.
- Latency:
  - Accept at edge N → mem_req high in cycle N+1.
  - Ack sampled at edge M → wb_regwr high in cycle M+1 (loads).
  - ls_ready high again in cycle M+2 for loads, M+1 for stores.
  - Minimum load = 3 cycles, minimum store = 2 cycles.
- mem_ack outside REQ is ignored.
- Outputs are all registered except ls_ready and stall.
- Counter clears on entry to REQ. No wrap: it saturates at TIMEOUT.

Optional Feature:
- Macro: LSU_STORE_FWD_EN.
- With macro defined:
  - A one-entry store buffer records address and data of the last acknowledged store (valid bit cleared on reset and on timeout).
  - A load whose address matches a valid entry skips memory: no mem_req. State goes directly to WB the cycle after accept, with wb_data = buffered data (2-cycle load).
  - A store to the same address updates the entry on its ack.
- Without macro: no buffer; every load goes to memory.

Test Plan:
- Reset mid-REQ: load to addr 0x0040, assert rst_n=0 before ack → mem_req=0 immediately. No wb_regwr; ls_ready=1 after release.
- Store: addr 0x1234, data 0xBEEF, ack after 3 cycles → mem_req high 3 cycles with mem_we=1, mem_addr=0x1234, mem_wdata=0xBEEF. ls_ready back high the cycle after ack; wb_regwr never asserts.
- Load: addr 0x0010, rd=5, ack with mem_rdata=0xA5A5 → wb_regwr=1 one cycle later for one cycle, wb_add_Rd=5, wb_data=0xA5A5. stall high while ls_valid held.
- Load rd=0: mem_rdata=0xFFFF → memory access completes; wb_regwr stays 0.
- Timeout: TIMEOUT=4, no ack → mem_req drops after 4 REQ cycles, err pulses once, no writeback. Separately, ack in the timeout cycle → normal completion with err=0.
- LSU_STORE_FWD_EN: store 0x0020←0x1111, then load 0x0020 rd=3 → no mem_req, wb_data=0x1111 two cycles after accept. Load 0x0021 → normal memory access.

Source files
------------

// File: rtl/lsu16.sv
// Load/store unit between the register file and data memory: req/ack memory handshake,
// single-cycle register writeback for loads, and a timeout abort. Optional store forwarding: LSU_STORE_FWD_EN.
module lsu16 #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  input  logic [3:0]  ls_rd,
  output logic        ls_ready,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        wb_regwr,
  output logic [3:0]  wb_add_Rd,
  output logic [15:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      rd_q, rd_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic            wb_regwr_q, wb_regwr_d;
  logic [3:0]      wb_add_Rd_q, wb_add_Rd_d;
  logic [15:0]     wb_data_q, wb_data_d;
  logic            err_q, err_d;

  logic            accept, ack_ok, to_hit, fwd_hit;
  logic [15:0]     fwd_data;

  assign accept  = ls_valid & (state_q == IDLE);
  assign ack_ok  = (state_q == REQ) & mem_ack;
  assign cnt_inc = cnt_q + TO_W'(1);
  // Ack has priority: a timeout only fires in a REQ cycle without ack.
  assign to_hit  = (state_q == REQ) & ~mem_ack & (cnt_inc == TO_W'(TIMEOUT));

`ifdef LSU_STORE_FWD_EN
  logic        sb_valid_q, sb_valid_d;
  logic [15:0] sb_addr_q, sb_addr_d;
  logic [15:0] sb_data_q, sb_data_d;

  assign fwd_hit  = accept & ~ls_write & sb_valid_q & (sb_addr_q == ls_addr);
  assign fwd_data = sb_data_q;

  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    if (ack_ok && mem_we_q) begin
      sb_valid_d = 1'b1;
      sb_addr_d  = mem_addr_q;
      sb_data_d  = mem_wdata_q;
    end else if (to_hit) begin
      sb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_q <= 1'b0;
      sb_addr_q  <= '0;
      sb_data_q  <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_addr_q  <= sb_addr_d;
      sb_data_q  <= sb_data_d;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_regwr_q  <= 1'b0;
      wb_add_Rd_q <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_regwr_q  <= wb_regwr_d;
      wb_add_Rd_q <= wb_add_Rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fwd_hit ? WB : REQ;
      REQ: begin
        if (mem_ack)     state_d = mem_we_q ? IDLE : WB;
        else if (to_hit) state_d = IDLE;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_regwr_d  = 1'b0;
    wb_add_Rd_d = wb_add_Rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d  = ls_rd;
          cnt_d = '0;
          if (fwd_hit) begin
            wb_regwr_d  = |ls_rd;
            wb_add_Rd_d = ls_rd;
            wb_data_d   = fwd_data;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = ls_write;
            mem_addr_d = ls_addr;
            if (ls_write) mem_wdata_d = ls_wdata;
          end
        end
      end
      REQ: begin
        if (ack_ok) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            // r0 is hardwired: the read still happens but the write is dropped.
            wb_regwr_d  = |rd_q;
            wb_add_Rd_d = rd_q;
            wb_data_d   = mem_rdata;
          end
        end else begin
          if (cnt_q != TO_W'(TIMEOUT)) cnt_d = cnt_inc;
          if (to_hit) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ls_ready  = (state_q == IDLE);
  assign stall     = ls_valid & ~ls_ready;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_regwr  = wb_regwr_q;
  assign wb_add_Rd = wb_add_Rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lsu16.sv
// Directed table-driven bench for lsu16 (TIMEOUT=4), plus hand sequences for reset, stall and stray acks.
module tb_lsu16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_valid, ls_write;
  logic [15:0] ls_addr, ls_wdata;
  logic [3:0]  ls_rd;
  logic        ls_ready, stall;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wb_regwr;
  logic [3:0]  wb_add_Rd;
  logic [15:0] wb_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  lsu16 #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rd(ls_rd),
    .ls_ready(ls_ready), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_regwr(wb_regwr), .wb_add_Rd(wb_add_Rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  rd;
    int          ack_at;     // cycle after accept in which ack is driven, 0 = never
    logic [15:0] rdata;
    int          exp_req;    // cycles with mem_req high
    int          exp_wb;     // wb_regwr pulses
    logic [15:0] exp_data;
    int          exp_err;    // err pulses
    int          exp_ready;  // first cycle after accept with ls_ready high
  } vec_t;

  typedef struct {
    int          req_cyc;
    int          req_bad;
    int          wb_cnt;
    int          wb_cyc;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    int          err_cnt;
    int          ready_cyc;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic [3:0] rd, input int ack, input logic [15:0] rdata,
                              input int ereq, input int ewb, input logic [15:0] edata,
                              input int eerr, input int erdy);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.rd = rd; v.ack_at = ack; v.rdata = rdata;
    v.exp_req = ereq; v.exp_wb = ewb; v.exp_data = edata; v.exp_err = eerr; v.exp_ready = erdy;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, output obs_t o);
    o.req_cyc = 0; o.req_bad = 0; o.wb_cnt = 0; o.wb_cyc = 0;
    o.wb_rd = '0; o.wb_data = '0; o.err_cnt = 0; o.ready_cyc = 0;
    @(negedge clk);
    ls_valid = 1'b1; ls_write = v.write; ls_addr = v.addr; ls_wdata = v.wdata; ls_rd = v.rd;
    @(negedge clk);
    ls_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (mem_req) begin
        o.req_cyc++;
        if (mem_we !== v.write || mem_addr !== v.addr || (v.write && mem_wdata !== v.wdata))
          o.req_bad++;
      end
      if (wb_regwr) begin
        o.wb_cnt++; o.wb_cyc = c; o.wb_rd = wb_add_Rd; o.wb_data = wb_data;
      end
      if (err) o.err_cnt++;
      if (ls_ready && o.ready_cyc == 0) o.ready_cyc = c;
      mem_ack   = (c == v.ack_at);
      mem_rdata = (c == v.ack_at) ? v.rdata : 16'hDEAD;
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  vec_t vecs[$];
  obs_t o;
  int   n_wb, n_err, n_req;

  initial begin
    rst_n = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; ls_addr = '0; ls_wdata = '0; ls_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //                write addr     wdata    rd  ack rdata    req wb data     err rdy
    vecs.push_back(mk(1, 16'h1234, 16'hBEEF, 0, 3, 16'h0000, 3, 0, 16'h0000, 0, 4));
    vecs.push_back(mk(0, 16'h0010, 16'h0000, 5, 2, 16'hA5A5, 2, 1, 16'hA5A5, 0, 4));
    vecs.push_back(mk(0, 16'h0011, 16'h0000, 0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 3));
    vecs.push_back(mk(1, 16'h0100, 16'h7777, 0, 0, 16'h0000, 4, 0, 16'h0000, 1, 5));
    vecs.push_back(mk(0, 16'h0200, 16'h0000, 7, 4, 16'h5A5A, 4, 1, 16'h5A5A, 0, 6));
    vecs.push_back(mk(0, 16'h0300, 16'h0000, 8, 0, 16'h0000, 4, 0, 16'h0000, 1, 5));
    vecs.push_back(mk(0, 16'h0003, 16'h0000, 15, 1, 16'h1357, 1, 1, 16'h1357, 0, 3));
    vecs.push_back(mk(1, 16'h0020, 16'h1111, 0, 1, 16'h0000, 1, 0, 16'h0000, 0, 2));
`ifdef LSU_STORE_FWD_EN
    vecs.push_back(mk(0, 16'h0020, 16'h0000, 3, 2, 16'h2222, 0, 1, 16'h1111, 0, 2));
`else
    vecs.push_back(mk(0, 16'h0020, 16'h0000, 3, 2, 16'h2222, 2, 1, 16'h2222, 0, 4));
`endif
    vecs.push_back(mk(0, 16'h0021, 16'h0000, 3, 1, 16'h3333, 1, 1, 16'h3333, 0, 3));
    vecs.push_back(mk(1, 16'h0020, 16'h9999, 0, 0, 16'h0000, 4, 0, 16'h0000, 1, 5));
    vecs.push_back(mk(0, 16'h0020, 16'h0000, 4, 1, 16'h4444, 1, 1, 16'h4444, 0, 3));
    vecs.push_back(mk(1, 16'h0030, 16'hAAAA, 0, 1, 16'h0000, 1, 0, 16'h0000, 0, 2));
    vecs.push_back(mk(1, 16'h0030, 16'hBBBB, 0, 2, 16'h0000, 2, 0, 16'h0000, 0, 3));
`ifdef LSU_STORE_FWD_EN
    vecs.push_back(mk(0, 16'h0030, 16'h0000, 6, 1, 16'hCCCC, 0, 1, 16'hBBBB, 0, 2));
`else
    vecs.push_back(mk(0, 16'h0030, 16'h0000, 6, 1, 16'hCCCC, 1, 1, 16'hCCCC, 0, 3));
`endif

    #12;
    chk("reset outputs", {mem_req, mem_we, mem_addr, mem_wdata, wb_regwr, wb_add_Rd, wb_data, err}, '0);
    chk("reset ls_ready", {31'd0, ls_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ls_ready", {31'd0, ls_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_txn(vecs[i], o);
      chk($sformatf("v%0d req_cycles", i), o.req_cyc, vecs[i].exp_req);
      chk($sformatf("v%0d req_fields", i), o.req_bad, 0);
      chk($sformatf("v%0d wb_pulses", i), o.wb_cnt, vecs[i].exp_wb);
      chk($sformatf("v%0d err_pulses", i), o.err_cnt, vecs[i].exp_err);
      chk($sformatf("v%0d ready_cycle", i), o.ready_cyc, vecs[i].exp_ready);
      if (vecs[i].exp_wb != 0) begin
        chk($sformatf("v%0d wb_cycle", i), o.wb_cyc, vecs[i].exp_ready - 1);
        chk($sformatf("v%0d wb_rd", i), {28'd0, o.wb_rd}, {28'd0, vecs[i].rd});
        chk($sformatf("v%0d wb_data", i), {16'd0, o.wb_data}, {16'd0, vecs[i].exp_data});
      end
    end

    // reset while a load waits for ack
    @(negedge clk);
    ls_valid = 1'b1; ls_write = 1'b0; ls_addr = 16'h0040; ls_rd = 4'd2;
    @(negedge clk);
    ls_valid = 1'b0;
    chk("rst pre mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mem_req drop", {31'd0, mem_req}, 32'd0);
    chk("rst ls_ready", {31'd0, ls_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h6666;
    n_wb = 0; n_err = 0; n_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      n_wb += int'(wb_regwr); n_err += int'(err); n_req += int'(mem_req);
    end
    chk("rst no wb", n_wb, 0);
    chk("rst no err", n_err, 0);
    chk("rst no req", n_req, 0);
    chk("rst ready after", {31'd0, ls_ready}, 32'd1);

    // stall while ls_valid held during a load
    @(negedge clk);
    ls_valid = 1'b1; ls_write = 1'b0; ls_addr = 16'h0050; ls_rd = 4'd9;
    @(negedge clk);
    chk("stall in REQ", {31'd0, stall}, 32'd1);
    chk("ready in REQ", {31'd0, ls_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stall in WB", {31'd0, stall}, 32'd1);
    chk("wb pulse", {31'd0, wb_regwr}, 32'd1);
    chk("wb data", {16'd0, wb_data}, {16'd0, 16'h0F0F});
    chk("wb rd", {28'd0, wb_add_Rd}, 32'd9);
    ls_valid = 1'b0;
    #1;
    chk("stall released", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("ready after WB", {31'd0, ls_ready}, 32'd1);
    chk("wb one cycle", {31'd0, wb_regwr}, 32'd0);

    // stray ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 16'h8888;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray ack", {mem_req, wb_regwr, err, ls_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
